async_fifo: RTL and testbench
=============================

Name: async_fifo

Overview:
- Single-clock first-in first-out buffer for 16-bit data words, with registered read data, full/empty status flags, a fill count, and sticky-free overflow/underflow pulses.
- Sits between a producer that asserts wr_en with data_in and a consumer that asserts rd_en and takes data_out one cycle later.
- The module keeps the async_fifo name for interface compatibility; producer and consumer share one clock domain.

Parameters:
- DATA_WIDTH, 16, width of data_in and data_out.
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH = 256 entries.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- data_in  input  DATA_WIDTH  write data, sampled on a clk edge with an accepted write.
- full  output  1  high when fill count == DEPTH.
- rd_en  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- empty  output  1  high when fill count == 0.
- fill_count  output  ADDR_WIDTH+1  number of stored words, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write requested while full and not accepted.
- underflow  output  1  one-cycle pulse: read requested while empty.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge): write pointer, read pointer and count go to 0; data_out=0; empty=1; full=0; overflow=0; underflow=0. Memory contents are not cleared. Reset has priority over all requests, including mid-operation; all stored data is discarded.
- Storage: DEPTH x DATA_WIDTH array. The write pointer and read pointer are ADDR_WIDTH bits and wrap modulo DEPTH naturally.
- Write acceptance: wr_en && (!full || rd_en). An accepted write stores data_in at the write pointer, then increments the write pointer.
- Read acceptance: rd_en && !empty.
  - An accepted read loads mem[read pointer] into data_out at that edge (1-cycle latency), then increments the read pointer.
  - data_out holds its last value when no read is accepted.
- There is no fall-through. A write and a read requested on the same edge while empty: the write is accepted, the read is rejected, and underflow pulses.
- Simultaneous accepted read and write (including when full): both occur and the count is unchanged. When full, the read takes the oldest word and the write fills the freed slot.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- full and empty are decoded combinationally from the registered count, so they change in the cycle after the causing edge.
- overflow is registered: set for one cycle after an edge where wr_en=1, full=1 and rd_en=0. Otherwise 0.
- underflow is registered: set for one cycle after an edge where rd_en=1 and empty=1. Otherwise 0.
- Ordering: words are read out in exactly the order they were accepted, across any number of pointer wraps.
- Rejected requests never change pointers, count, memory or data_out.

Test Plan:
- Reset: hold rst=1 for 10 cycles, then release -> empty=1, full=0, fill_count=0, data_out=0, no overflow/underflow pulses.
- Fill: wr_en=1 for 300 cycles with data_in counting 0,1,2,... -> after 256 accepted writes (values 0..255), full=1 and fill_count=256. Writes of 256..299 are dropped, with overflow=1 on each of those 44 cycles.
- Drain: wr_en=0, rd_en=1 for 300 cycles -> data_out shows 0..255 in order, each one cycle after its read edge. empty=1 after the 256th read; underflow pulses on the remaining 44 cycles; data_out holds 255.
- Concurrent at full: fill to 256, then assert wr_en=1 and rd_en=1 with data_in=0xAAAA for 1 cycle -> data_out=oldest word, fill_count stays 256, full stays 1, no overflow. 0xAAAA is read out last.
- Wrap-around: run 1000 cycles with wr_en=1 and rd_en=1 at random 50% duty, data_in incrementing -> the read sequence is strictly consecutive with no gaps or duplicates, fill_count matches the scoreboard every cycle, and pointers wrap multiple times.
- Mid-operation reset: write 100 words, assert rst for 1 cycle -> empty=1, fill_count=0. A following read returns only words written after the reset (first value equals the first post-reset data_in).

Source files
------------

// File: rtl/async_fifo.sv
// rtl/async_fifo.sv - single-clock 16-bit FIFO with registered read data and status flags
//
// Purpose:
//   First-in first-out buffer between a producer (wr_en/data_in) and a
//   consumer (rd_en, data_out one cycle later). Producer and consumer share
//   one clock; the async_fifo name is kept for interface compatibility.
//
// Ports:
//   clk         in   single clock, all state updates on its rising edge
//   rst         in   synchronous active-high reset, priority over requests
//   wr_en       in   write request
//   data_in     in   write data, stored on an accepted write
//   full        out  fill_count == DEPTH
//   rd_en       in   read request
//   data_out    out  registered read data, holds when no read is accepted
//   empty       out  fill_count == 0
//   fill_count  out  stored words, 0..DEPTH
//   overflow    out  one-cycle pulse after a write rejected because full
//   underflow   out  one-cycle pulse after a read requested while empty

module async_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   C_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   C_CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  // Flags decode from the registered count, so they trail the causing edge.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // A write while full is still accepted when a read frees the oldest slot
  // on the same edge. No fall-through: a read while empty is always rejected,
  // even if a write is accepted on the same edge.
  assign w_wr_ok = wr_en && (!w_full || rd_en);
  assign w_rd_ok = rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_rd_ok) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_overflow  <= wr_en && w_full && !rd_en;
      r_underflow <= rd_en && w_empty;
    end
  end

  // Storage is not reset; the pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  assign full       = w_full;
  assign empty      = w_empty;
  assign fill_count = r_count;
  assign data_out   = r_data_out;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_async_fifo.sv
// tb/tb_async_fifo.sv - directed self-checking bench for async_fifo
module tb_async_fifo;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [15:0] data_in;
  logic        full;
  logic        rd_en;
  logic [15:0] data_out;
  logic        empty;
  logic [8:0]  fill_count;
  logic        overflow;
  logic        underflow;

  int n_vec;
  int n_miss;

  async_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .full       (full),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .empty      (empty),
    .fill_count (fill_count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int q[$];
    int next_wr;
    int next_rd;
    int cnt;
    logic wo;
    logic ro;

    n_vec   = 0;
    n_miss  = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;

    // Reset
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b0;
    tick();
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(fill_count), 0);
    check("rst_dout", 32'(data_out), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);

    // Fill: 300 writes, 256 accepted, 44 overflow pulses
    wr_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      data_in = 16'(i);
      tick();
      check("fill_count", 32'(fill_count), (i < 256) ? i + 1 : 256);
      check("fill_full", 32'(full), (i >= 255) ? 1 : 0);
      check("fill_ovf", 32'(overflow), (i >= 256) ? 1 : 0);
    end
    wr_en = 1'b0;

    // Drain: 300 reads, 0..255 in order, 44 underflow pulses
    rd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      check("drain_dout", 32'(data_out), (i < 256) ? i : 255);
      check("drain_empty", 32'(empty), (i >= 255) ? 1 : 0);
      check("drain_unf", 32'(underflow), (i >= 256) ? 1 : 0);
      check("drain_count", 32'(fill_count), (i < 256) ? 255 - i : 0);
    end
    rd_en = 1'b0;
    tick();
    check("unf_clear", 32'(underflow), 0);

    // Concurrent read+write at full
    wr_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      data_in = 16'(32'h1000 + i);
      tick();
    end
    check("cf_full", 32'(full), 1);
    rd_en   = 1'b1;
    data_in = 16'hAAAA;
    tick();
    check("cf_dout", 32'(data_out), 32'h1000);
    check("cf_count", 32'(fill_count), 256);
    check("cf_full2", 32'(full), 1);
    check("cf_ovf", 32'(overflow), 0);
    wr_en = 1'b0;
    for (int i = 1; i < 256; i++) begin
      tick();
      check("cf_drain", 32'(data_out), 32'h1000 + i);
    end
    tick();
    check("cf_last", 32'(data_out), 32'hAAAA);
    check("cf_empty", 32'(empty), 1);
    rd_en = 1'b0;
    tick();

    // Wrap-around: random duty, scoreboard on count, consecutive read check
    next_wr = 0;
    next_rd = 0;
    cnt     = 0;
    for (int i = 0; i < 1000; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      data_in = 16'(next_wr);
      wo = wr_en && ((cnt < 256) || rd_en);
      ro = rd_en && (cnt > 0);
      if (ro) void'(q.pop_front());
      if (wo) begin
        q.push_back(next_wr);
        next_wr++;
      end
      cnt = q.size();
      tick();
      check("wrap_count", 32'(fill_count), cnt);
      if (ro) begin
        check("wrap_seq", 32'(data_out), 32'(16'(next_rd)));
        next_rd++;
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;

    // Mid-operation reset, asserted together with a write request
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      data_in = 16'(32'h5000 + i);
      tick();
    end
    check("mid_count100", 32'(fill_count), 100);
    rst     = 1'b1;
    data_in = 16'h6666;
    tick();
    rst = 1'b0;
    check("mid_empty", 32'(empty), 1);
    check("mid_count", 32'(fill_count), 0);
    check("mid_dout", 32'(data_out), 0);

    // Write and read on the same edge while empty: no fall-through
    rd_en   = 1'b1;
    data_in = 16'h7777;
    tick();
    check("nft_unf", 32'(underflow), 1);
    check("nft_count", 32'(fill_count), 1);
    check("nft_dout", 32'(data_out), 0);
    wr_en = 1'b0;
    tick();
    check("mid_first", 32'(data_out), 32'h7777);
    check("mid_empty2", 32'(empty), 1);
    check("mid_unf2", 32'(underflow), 0);
    rd_en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
